gpr_wb_ctrl: RTL and testbench

Write-side controller for the 32x64 general-purpose register file. Accepts completed results from the ALU path and the load/store unit (LSU) over valid/ready handshakes, and arbitrates between them. Sign- or zero-extends load data, then drives the register file write port (rd index, data, enable) from registered outputs. Keeps a pending-load scoreboard so decode can stall on load-use hazards.

---
 rtl/gpr_wb_ctrl.sv | 122 ++++++++++++
 tb/tb_gpr_wb_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_wb_ctrl.sv
// Write-back controller for the 32x64 register file: arbitrates ALU and LSU results,
// extends load data, registers the write port and tracks outstanding loads.
`timescale 1ns/1ps

module gpr_wb_ctrl #(
    parameter int XLEN         = 64,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic            issue_is_load,
    input  logic [4:0]      issue_rd,
    output logic            issue_ready,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic [1:0]      lsu_size,
    input  logic            lsu_unsigned,
    output logic            lsu_ready,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_en,
    output logic [31:0]     busy_mask
);

    logic [CNT_W-1:0] r_starveCnt;
    logic [31:0]      r_busy;
    logic             r_wbEn;
    logic [4:0]       r_wbRd;
    logic [XLEN-1:0]  r_wbData;

    logic             w_starved;
    logic             w_aluAcc;
    logic             w_lsuAcc;
    logic             w_issueSet;
    logic [4:0]       w_accRd;
    logic [XLEN-1:0]  w_accData;
    logic [XLEN-1:0]  w_loadExt;
    logic [31:0]      w_busyNext;

    assign w_starved = (r_starveCnt == CNT_W'(STARVE_LIMIT));

    // LSU normally wins; once the ALU has stalled long enough it gets one guaranteed slot.
    always_comb begin
        alu_ready   = 1'b0;
        lsu_ready   = 1'b0;
        issue_ready = 1'b0;
        if (!rst) begin
            lsu_ready   = !w_starved;
            alu_ready   = w_starved || !lsu_valid;
            issue_ready = !(issue_is_load && r_busy[issue_rd]);
        end
    end

    assign w_aluAcc   = alu_valid && alu_ready;
    assign w_lsuAcc   = lsu_valid && lsu_ready;
    assign w_issueSet = issue_valid && issue_is_load && issue_ready && (issue_rd != 5'd0);

    always_comb begin
        w_loadExt = lsu_data;
        case (lsu_size)
            2'd0:    w_loadExt = {{(XLEN-8){!lsu_unsigned && lsu_data[7]}},   lsu_data[7:0]};
            2'd1:    w_loadExt = {{(XLEN-16){!lsu_unsigned && lsu_data[15]}}, lsu_data[15:0]};
            2'd2:    w_loadExt = {{(XLEN-32){!lsu_unsigned && lsu_data[31]}}, lsu_data[31:0]};
            default: w_loadExt = lsu_data;
        endcase
    end

    always_comb begin
        w_accRd   = lsu_rd;
        w_accData = w_loadExt;
        if (w_aluAcc) begin
            w_accRd   = alu_rd;
            w_accData = alu_data;
        end
    end

    // A new load issue to the same index overrides the clear from a returning response.
    always_comb begin
        w_busyNext = r_busy;
        if (w_lsuAcc) begin
            w_busyNext[lsu_rd] = 1'b0;
        end
        if (w_issueSet) begin
            w_busyNext[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starveCnt <= '0;
            r_busy      <= '0;
            r_wbEn      <= 1'b0;
            r_wbRd      <= '0;
            r_wbData    <= '0;
        end else begin
            r_busy <= w_busyNext;
            r_wbEn <= (w_aluAcc || w_lsuAcc) && (w_accRd != 5'd0);
            if (w_aluAcc || w_lsuAcc) begin
                r_wbRd   <= w_accRd;
                r_wbData <= w_accData;
            end
            if (w_aluAcc) begin
                r_starveCnt <= '0;
            end else if (alu_valid && !alu_ready && !w_starved) begin
                r_starveCnt <= r_starveCnt + CNT_W'(1);
            end
        end
    end

    assign wb_en     = r_wbEn;
    assign wb_rd     = r_wbRd;
    assign wb_data   = r_wbData;
    assign busy_mask = r_busy;

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Bench for gpr_wb_ctrl: directed literal cases, then random traffic compared every
// cycle against a behavioural model of arbitration, extension and the load scoreboard.
`timescale 1ns/1ps

module tb_gpr_wb_ctrl;

    localparam int XLEN   = 64;
    localparam int STARVE = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            issue_valid, issue_is_load, issue_ready;
    logic [4:0]      issue_rd;
    logic            alu_valid, alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid, lsu_unsigned, lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic [1:0]      lsu_size;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            wb_en;
    logic [31:0]     busy_mask;

    int checksTotal  = 0;
    int checksPassed = 0;

    always #5 clk = ~clk;

    gpr_wb_ctrl #(.XLEN(XLEN), .STARVE_LIMIT(STARVE), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_is_load(issue_is_load), .issue_rd(issue_rd),
        .issue_ready(issue_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_size(lsu_size),
        .lsu_unsigned(lsu_unsigned), .lsu_ready(lsu_ready),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_en(wb_en), .busy_mask(busy_mask)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checksTotal++;
        if (actual === expected) checksPassed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    task automatic applyStimulus(input logic r,
                                 input logic iv, input logic il, input logic [4:0] ird,
                                 input logic av, input logic [4:0] ard, input logic [63:0] ad,
                                 input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
                                 input logic [1:0] lsz, input logic lu);
        rst = r;
        issue_valid = iv; issue_is_load = il; issue_rd = ird;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld; lsu_size = lsz; lsu_unsigned = lu;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 2'd0, 1'b0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Load extension stated as arithmetic on the access width.
    function automatic logic [63:0] extendLoad(input logic [63:0] d, input logic [1:0] sz,
                                               input logic uns);
        int bits;
        logic [63:0] m;
        logic [63:0] v;
        bits = 8 << sz;
        if (bits == 64) return d;
        m = (64'd1 << bits) - 64'd1;
        v = d & m;
        if (!uns && d[bits-1]) v = v | ~m;
        return v;
    endfunction

    // Behavioural model state.
    bit          mLive = 0;
    int          mStall;
    logic [31:0] mMask;
    logic        mWbEn;
    logic [4:0]  mWbRd;
    logic [63:0] mWbData;
    logic        eAlu, eLsu, eIss, aAcc, lAcc;

    always @(negedge clk) begin
        if (mLive) begin
            checkOutput("wb_en", wb_en, mWbEn);
            checkOutput("wb_rd", wb_rd, mWbRd);
            checkOutput("wb_data", wb_data, mWbData);
            checkOutput("busy_mask", busy_mask, mMask);
        end
        if (rst) begin
            checkOutput("alu_ready_rst", alu_ready, 1'b0);
            checkOutput("lsu_ready_rst", lsu_ready, 1'b0);
            mStall = 0; mMask = '0; mWbEn = 0; mWbRd = '0; mWbData = '0;
            mLive = 1;
        end else if (mLive) begin
            eLsu = (mStall < STARVE);
            eAlu = (mStall == STARVE) || !lsu_valid;
            eIss = !(issue_is_load && mMask[issue_rd]);
            checkOutput("alu_ready", alu_ready, eAlu);
            checkOutput("lsu_ready", lsu_ready, eLsu);
            checkOutput("issue_ready", issue_ready, eIss);
            aAcc = alu_valid && eAlu;
            lAcc = lsu_valid && eLsu;
            mWbEn = 0;
            if (aAcc) begin
                mWbRd = alu_rd; mWbData = alu_data; mWbEn = (alu_rd != 0);
            end else if (lAcc) begin
                mWbRd = lsu_rd; mWbData = extendLoad(lsu_data, lsu_size, lsu_unsigned);
                mWbEn = (lsu_rd != 0);
            end
            if (aAcc) mStall = 0;
            else if (alu_valid && mStall < STARVE) mStall++;
            if (lAcc) mMask[lsu_rd] = 1'b0;
            if (issue_valid && issue_is_load && eIss && issue_rd != 0) mMask[issue_rd] = 1'b1;
        end
    end

    task automatic doLoad(input logic [63:0] d, input logic [1:0] sz, input logic uns,
                          input logic [63:0] expected, input string name);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd1, d, sz, uns);
        @(negedge clk);
        checkOutput({name, "_ready"}, lsu_ready, 1'b1);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput({name, "_en"}, wb_en, 1'b1);
        checkOutput(name, wb_data, expected);
        nextCycle();
    endtask

    initial begin
        logic [5:0] aluPattern;
        logic       aluHeld, lsuHeld;
        aluPattern = 6'b010000;

        // Reset held with a pending ALU result, then released: the result is taken at once.
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0, 2'd0, 1'b0);
        @(negedge clk);
        checkOutput("rst_alu_ready", alu_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_wb_en", wb_en, 1'b0);
        checkOutput("rst_busy", busy_mask, 32'd0);
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("release_alu_ready", alu_ready, 1'b1);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("alu_wb_en", wb_en, 1'b1);
        checkOutput("alu_wb_rd", wb_rd, 5'd5);
        checkOutput("alu_wb_data", wb_data, 64'h1234);
        nextCycle();
        @(negedge clk);
        checkOutput("alu_wb_en_drop", wb_en, 1'b0);
        nextCycle();

        doLoad(64'h80, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, "ld_byte_s");
        doLoad(64'h80, 2'd0, 1'b1, 64'h80, "ld_byte_u");
        doLoad(64'hDEAD_BEEF_8765_4321, 2'd2, 1'b0, 64'hFFFF_FFFF_8765_4321, "ld_word_s");
        doLoad(64'hDEAD_BEEF_8765_4321, 2'd3, 1'b1, 64'hDEAD_BEEF_8765_4321, "ld_dbl");

        // Continuous contention: four LSU accepts, one ALU accept, then LSU again.
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 64'hAAAA, 1'b1, 5'd3, 64'h55, 2'd3, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput($sformatf("starve_alu_%0d", i), alu_ready, aluPattern[i]);
            checkOutput($sformatf("starve_lsu_%0d", i), lsu_ready, !aluPattern[i]);
            nextCycle();
        end
        lsu_valid = 1'b0;
        nextCycle();

        // x0 destination: accepted but never written.
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 64'hFF, 1'b0, 5'd0, 64'd0, 2'd0, 1'b0);
        @(negedge clk);
        checkOutput("x0_alu_ready", alu_ready, 1'b1);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("x0_wb_en", wb_en, 1'b0);
        nextCycle();

        // Scoreboard set, WAW hold, clear, and set-wins-over-clear.
        applyStimulus(1'b0, 1'b1, 1'b1, 5'd10, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 2'd0, 1'b0);
        @(negedge clk);
        checkOutput("sb_first_issue", issue_ready, 1'b1);
        nextCycle();
        @(negedge clk);
        checkOutput("sb_mask_set", busy_mask, 32'h400);
        checkOutput("sb_waw_hold", issue_ready, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd10, 64'h7, 2'd3, 1'b0);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("sb_mask_clear", busy_mask, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 5'd10, 1'b0, 5'd0, 64'd0, 1'b1, 5'd10, 64'h9, 2'd3, 1'b0);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("sb_set_wins", busy_mask, 32'h400);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd10, 64'h9, 2'd3, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 2'd0, 1'b0);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("sb_x0_issue", busy_mask, 32'd0);
        nextCycle();

        // Random traffic; a stalled source keeps its payload until accepted.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            aluHeld = alu_valid && !alu_ready && !rst;
            lsuHeld = lsu_valid && !lsu_ready && !rst;
            nextCycle();
            rst = ($urandom_range(0, 60) == 0);
            if (!aluHeld) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_rd    = 5'($urandom_range(0, 7));
                alu_data  = {$urandom, $urandom};
            end
            if (!lsuHeld) begin
                lsu_valid    = ($urandom_range(0, 2) != 0);
                lsu_rd       = 5'($urandom_range(0, 7));
                lsu_data     = {$urandom, $urandom};
                lsu_size     = 2'($urandom_range(0, 3));
                lsu_unsigned = 1'($urandom_range(0, 1));
            end
            issue_valid   = 1'($urandom_range(0, 1));
            issue_is_load = 1'($urandom_range(0, 1));
            issue_rd      = 5'($urandom_range(0, 7));
        end

        idle();
        repeat (3) nextCycle();
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
